// File: rtl/display_source_scheduler.sv
// rtl/display_source_scheduler.sv - rotates four CPU-written slots onto a hex display with debug override
// Optional feature macro: DISPLAY_BLINK_EN (blank blinks while the debug requester owns the display)
module display_source_scheduler #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic        pause,
    input  logic        dbg_req,
    input  logic [31:0] dbg_data,
    output logic        dbg_ack,
    output logic [31:0] data_to_display,
    output logic [1:0]  active_slot,
    output logic        blank
);

    localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

    typedef enum logic {
        ST_ROTATE = 1'b0,
        ST_DEBUG  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    active_slot_q, active_slot_d;
    logic [31:0]   slot_q [4];
    logic [31:0]   slot_d [4];
    logic [3:0]    valid_q, valid_d;
    logic [31:0]   data_q, data_d;
    logic          dbg_ack_q, dbg_ack_d;
    logic [1:0]    next_slot;

    // Next valid slot after the active one (ascending, wrapping); stays put if none other is valid.
    // Uses the pre-edge valid bits so a same-cycle write cannot influence the advance.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        next_slot = active_slot_q;
        found     = 1'b0;
        idx       = 2'd0;
        for (int i = 1; i < 4; i++) begin
            idx = active_slot_q + 2'(i);
            if (!found && valid_q[idx]) begin
                next_slot = idx;
                found     = 1'b1;
            end
        end
    end

    // Next-state logic: FSM, dwell counter, rotation, slot writes and display word selection.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        active_slot_d = active_slot_q;
        slot_d        = slot_q;
        valid_d       = valid_q;

        // Display word reflects the selection seen at this edge (pre-edge state and registers).
        if (state_q == ST_DEBUG) begin
            data_d = dbg_data;
        end else if (valid_q[active_slot_q]) begin
            data_d = slot_q[active_slot_q];
        end else begin
            data_d = 32'h0;
        end

        case (state_q)
            ST_ROTATE: begin
                if (dbg_req) begin
                    state_d = ST_DEBUG;
                end else if (!pause) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d         = '0;
                        active_slot_d = next_slot;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DEBUG: begin
                if (!dbg_req) begin
                    state_d = ST_ROTATE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_ROTATE;
                cnt_d   = '0;
            end
        endcase

        // Writes are accepted in every state and never gated by pause.
        if (wr_en) begin
            slot_d[wr_sel]  = wr_data;
            valid_d[wr_sel] = 1'b1;
        end

        dbg_ack_d = (state_d == ST_DEBUG);
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ROTATE;
            cnt_q         <= '0;
            active_slot_q <= 2'd0;
            valid_q       <= 4'b0000;
            data_q        <= 32'h0;
            dbg_ack_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= 32'h0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            active_slot_q <= active_slot_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            dbg_ack_q     <= dbg_ack_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blank_q, blank_d;

    // Blink phase: restarts low on debug entry, toggles every BLINK_CYCLES while in debug.
    always_comb begin
        blink_cnt_d = '0;
        blank_d     = 1'b0;
        if (state_q == ST_DEBUG && state_d == ST_DEBUG) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blank_d     = ~blank_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blank_d     = blank_q;
            end
        end
    end

    // Blink register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

    assign dbg_ack         = dbg_ack_q;
    assign data_to_display = data_q;
    assign active_slot     = active_slot_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// tb/tb_display_source_scheduler.sv - scoreboard bench for display_source_scheduler
module tb_display_source_scheduler;

    localparam int DWELL = 4;
    localparam int BLINK = 2;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;
    logic        pause;
    logic        dbg_req;
    logic [31:0] dbg_data;
    logic        dbg_ack;
    logic [31:0] data_to_display;
    logic [1:0]  active_slot;
    logic        blank;

    display_source_scheduler #(
        .DWELL_CYCLES(DWELL),
        .BLINK_CYCLES(BLINK)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_sel         (wr_sel),
        .wr_data        (wr_data),
        .pause          (pause),
        .dbg_req        (dbg_req),
        .dbg_data       (dbg_data),
        .dbg_ack        (dbg_ack),
        .data_to_display(data_to_display),
        .active_slot    (active_slot),
        .blank          (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  slot;
        logic        ack;
        logic        blank;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic        m_dbg;
    int          m_cnt;
    logic [1:0]  m_act;
    logic [31:0] m_slot [4];
    logic [3:0]  m_valid;
    logic [31:0] m_data;
    logic        m_blank;
    int          m_bcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_dbg   = 1'b0;
        m_cnt   = 0;
        m_act   = 2'd0;
        m_valid = 4'b0;
        m_data  = 32'h0;
        m_blank = 1'b0;
        m_bcnt  = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = 32'h0;
    endtask

    // Advance the model one clock edge from the currently driven inputs and push the expectation.
    task automatic model_edge();
        exp_t       e;
        logic [1:0] cand;
        logic       was_dbg;
        was_dbg = m_dbg;
        m_data  = m_dbg ? dbg_data : (m_valid[m_act] ? m_slot[m_act] : 32'h0);
        if (m_dbg) begin
            if (!dbg_req) begin
                m_dbg = 1'b0;
                m_cnt = 0;
            end
        end else if (dbg_req) begin
            m_dbg = 1'b1;
        end else if (!pause) begin
            if (m_cnt == DWELL - 1) begin
                m_cnt = 0;
                cand  = m_act;
                // search candidates 1..3 positions ahead; first valid one wins
                for (int k = 3; k >= 1; k--) begin
                    if (m_valid[2'(m_act + 2'(k))]) cand = 2'(m_act + 2'(k));
                end
                m_act = cand;
            end else begin
                m_cnt++;
            end
        end
        if (wr_en) begin
            m_slot[wr_sel]  = wr_data;
            m_valid[wr_sel] = 1'b1;
        end
`ifdef DISPLAY_BLINK_EN
        if (was_dbg && m_dbg) begin
            m_bcnt++;
            if (m_bcnt == BLINK) begin
                m_bcnt  = 0;
                m_blank = ~m_blank;
            end
        end else begin
            m_bcnt  = 0;
            m_blank = 1'b0;
        end
`else
        m_blank = 1'b0;
        m_bcnt  = was_dbg ? 0 : 0;
`endif
        e.data  = m_data;
        e.slot  = m_act;
        e.ack   = m_dbg;
        e.blank = m_blank;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("data", data_to_display, e.data);
            check("slot", 32'(active_slot), 32'(e.slot));
            check("ack", 32'(dbg_ack), 32'(e.ack));
            check("blank", 32'(blank), 32'(e.blank));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_tick(input logic [1:0] sel, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int guard;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_sel   = 2'd0;
        wr_data  = 32'h0;
        pause    = 1'b0;
        dbg_req  = 1'b0;
        dbg_data = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_to_display, 32'h0);
        check("rst_slot", 32'(active_slot), 32'd0);
        check("rst_ack", 32'(dbg_ack), 32'd0);
        check("rst_blank", 32'(blank), 32'd0);
        rst = 1'b0;

        // no writes: nothing to rotate onto
        ticks(20);
        check("idle_slot", 32'(active_slot), 32'd0);

        // two valid slots alternate
        write_tick(2'd0, 32'h12345678);
        write_tick(2'd2, 32'hDEADBEEF);
        ticks(20);

        // debug takeover mid-dwell
        ticks(2);
        dbg_data = 32'hABCDEF00;
        dbg_req  = 1'b1;
        tick();
        check("dbg_ack_entry", 32'(dbg_ack), 32'd1);
        tick();
        check("dbg_data_shown", data_to_display, 32'hABCDEF00);
        ticks(6);
        dbg_req = 1'b0;
        ticks(10);

        // write slot1 on slot0's terminal count: skipped now, included next time round
        guard = 0;
        while (!(m_cnt == DWELL - 1 && m_act == 2'd0) && guard < 40) begin
            tick();
            guard++;
        end
        check("terminal_reached", 32'(guard < 40), 32'd1);
        write_tick(2'd1, 32'h0000C0DE);
        check("skip_new_slot", 32'(active_slot), 32'd2);
        ticks(DWELL);
        check("wrap_to_0", 32'(active_slot), 32'd0);
        ticks(DWELL);
        check("include_slot1", 32'(active_slot), 32'd1);

        // pause mid-dwell, with a write accepted while paused
        ticks(2);
        pause = 1'b1;
        ticks(4);
        write_tick(2'd3, 32'h33333333);
        ticks(5);
        pause = 1'b0;
        ticks(12);

        // randomized mix
        for (int i = 0; i < 80; i++) begin
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_sel   = 2'($urandom_range(0, 3));
            wr_data  = $urandom;
            pause    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) dbg_req = ~dbg_req;
            dbg_data = $urandom;
            tick();
        end
        wr_en   = 1'b0;
        pause   = 1'b0;
        dbg_req = 1'b0;
        ticks(3);

        // long debug hold (exercises blink when enabled), then async reset inside debug
        dbg_data = 32'h5A5A5A5A;
        dbg_req  = 1'b1;
        ticks(9);
        #2;
        rst = 1'b1;
        #1;
        check("async_ack", 32'(dbg_ack), 32'd0);
        check("async_blank", 32'(blank), 32'd0);
        check("async_data", data_to_display, 32'h0);
        check("async_slot", 32'(active_slot), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        dbg_req = 1'b0;
        rst     = 1'b0;
        ticks(12);
        check("post_rst_slot", 32'(active_slot), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
